// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared definitions for the counter-chain sequencer.
package cnt_seq_ctrl_pkg;

    // Sequencer states; encodings match the legacy 2-bit codes.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cnt_seq_ctrl_unit.sv
// Single ripple-enable counter cell: toggles when enabled, carries when set.
module cnt_unit (
    input  logic ck,
    input  logic res,
    input  logic en,
    output logic q,
    output logic ca
);

    // Toggle flop with synchronous clear.
    always_ff @(posedge ck) begin
        if (res)
            q <= 1'b0;
        else if (en)
            q <= ~q;
    end

    // Carry ripples the enable to the next cell when this cell is about to roll over.
    always_comb begin
        ca = en & q;
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Run/stop/clear sequencer driving a chain of W cnt_unit cells, with a
// loadable terminal count and a one-cycle done pulse.
module cnt_seq_ctrl
    import cnt_seq_ctrl_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         ck,
    input  logic         res,
    input  logic         start,
    input  logic         stop,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] tc_in,
    output logic [W-1:0] count,
    output logic         running,
    output logic         done
);

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] tc;
    logic         chain_en;
    logic         cnt_res;
    logic         done_set;
    logic         go;
    logic [W-1:0] en;
    logic [W-1:0] ca;
    logic         carry_out_unused;

    assign go               = start & ~stop;
    assign carry_out_unused = ca[W-1];

    // Counter chain: cell 0 takes the chain enable, each later cell the carry below it.
    for (genvar i = 0; i < W; i++) begin : g_cell
        if (i == 0) begin : g_first
            assign en[i] = chain_en;
        end else begin : g_next
            assign en[i] = ca[i-1];
        end
        cnt_unit u_cell (
            .ck  (ck),
            .res (cnt_res),
            .en  (en[i]),
            .q   (count[i]),
            .ca  (ca[i])
        );
    end

    // State register.
    always_ff @(posedge ck) begin
        if (res)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state decode; clr beats stop beats start.
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (go) state_nx = S_RUN;
                S_RUN: begin
                    if (stop)
                        state_nx = S_PAUSE;
                    else if (count == tc)
                        state_nx = S_DONE;
                end
                S_PAUSE: if (go) state_nx = S_RUN;
                S_DONE:  if (go) state_nx = S_RUN;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Output decode. The chain enable is also gated by stop/clr so the edge
    // that leaves RUN never increments.
    always_comb begin
        running  = (state == S_RUN);
        chain_en = running & ~stop & ~clr & (count != tc);
        done_set = running & ~stop & ~clr & (count == tc);
        cnt_res  = res | clr | ((state == S_DONE) & go);
    end

    // Terminal-count register, writable only while idle or finished.
    always_ff @(posedge ck) begin
        if (res)
            tc <= '1;
        else if (load && (state == S_IDLE || state == S_DONE))
            tc <= tc_in;
    end

    // Done pulse, registered so it appears the cycle after reaching tc.
    always_ff @(posedge ck) begin
        if (res)
            done <= 1'b0;
        else
            done <= done_set;
    end

endmodule
